// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared FSM encodings and the 10011 search pattern
// used by seq_scan_ctrl and its detector.
package seq_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  // Detector progress: number of pattern bits matched so far.
  typedef enum logic [2:0] {
    D0,
    D1,
    D2,
    D3,
    D4
  } det_state_t;

  localparam logic [4:0] PATTERN = 5'b10011;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: job request/result bundle of seq_scan_ctrl.
// master drives start/data_in/msb_first; slave returns busy/done/results.
interface seq_scan_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);
  localparam int POS_W = $clog2(DATA_W);

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              msb_first;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  det_count;
  logic              found;
  logic [POS_W-1:0]  first_pos;

  modport master (
    output start, data_in, msb_first,
    input  busy, done, det_count, found, first_pos
  );

  modport slave (
    input  start, data_in, msb_first,
    output busy, done, det_count, found, first_pos
  );
endinterface

// File: rtl/seq10011_det.sv
// seq10011_det: non-overlapping Mealy 10011 detector, registered flag.
// Ports: clk, reset/clear (sync, active-high), din, seq_detected.
module seq10011_det
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic din,
  output logic seq_detected
);

  det_state_t st, nx;

  // On a mismatch, fall back to the longest pattern prefix that is
  // still a suffix of the bits seen; a full match restarts at D0.
  always_comb begin
    nx = st;
    unique case (st)
      D0: nx = (din == PATTERN[4]) ? D1 : D0;
      D1: nx = (din == PATTERN[3]) ? D2 : D1;
      D2: nx = (din == PATTERN[2]) ? D3 : D1;
      D3: nx = (din == PATTERN[1]) ? D4 : D0;
      D4: nx = (din == PATTERN[0]) ? D0 : D2;
      default: nx = D0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      st           <= D0;
      seq_detected <= 1'b0;
    end else begin
      st           <= nx;
      seq_detected <= (st == D4) && (din == PATTERN[0]);
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: scans a captured word bit-serially for 10011, counting hits.
// Ports: clk, reset (sync, active-high), bus (seq_scan_ctrl_if.slave).
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic            clk,
  input  logic            reset,
  seq_scan_ctrl_if.slave  bus
);

  localparam int POS_W = $clog2(DATA_W);
  localparam logic [POS_W-1:0] LAST = POS_W'(DATA_W - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] word;
  logic              order;
  logic [POS_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              hit;
  logic [POS_W-1:0]  pos;

  logic              det_clr;
  logic              din;
  logic              flag;
  logic              count_en;
  logic [POS_W-1:0]  hit_pos;

  assign din = order ? word[LAST - idx] : word[idx];

  seq10011_det u_det (
    .clk          (clk),
    .reset        (reset),
    .clear        (det_clr),
    .din          (din),
    .seq_detected (flag)
  );

  // The flag lags its completing bit by one cycle, so a flag seen at
  // index i belongs to bit i-1, and one seen in DRAIN to the last bit.
  always_comb begin
    state_nx = state;
    det_clr  = 1'b0;
    count_en = 1'b0;
    hit_pos  = idx - POS_W'(1);
    unique case (state)
      IDLE: begin
        if (bus.start) state_nx = CLEAR;
      end
      CLEAR: begin
        det_clr  = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        count_en = flag && (idx != '0);
        if (idx == LAST) state_nx = DRAIN;
      end
      DRAIN: begin
        count_en = flag;
        hit_pos  = LAST;
        state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      word  <= '0;
      order <= 1'b0;
      idx   <= '0;
      cnt   <= '0;
      hit   <= 1'b0;
      pos   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        word  <= bus.data_in;
        order <= bus.msb_first;
        cnt   <= '0;
        hit   <= 1'b0;
        pos   <= '0;
      end
      if (state == CLEAR) idx <= '0;
      if (state == SHIFT) idx <= (idx == LAST) ? '0 : idx + POS_W'(1);
      if (count_en) begin
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
        if (!hit) begin
          hit <= 1'b1;
          pos <= hit_pos;
        end
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.det_count = cnt;
  assign bus.found     = hit;
  assign bus.first_pos = pos;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed bench for seq_scan_ctrl (CNT_W=5 and CNT_W=1
// instances driven in parallel).
module tb_seq_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.DATA_W(16), .CNT_W(5)) bus ();
  seq_scan_ctrl_if #(.DATA_W(16), .CNT_W(1)) bus1 ();

  assign bus1.start     = bus.start;
  assign bus1.data_in   = bus.data_in;
  assign bus1.msb_first = bus.msb_first;

  seq_scan_ctrl #(.DATA_W(16), .CNT_W(5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_scan_ctrl #(.DATA_W(16), .CNT_W(1)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    while (edges < 40 && bus.done !== 1'b1) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  // Edge 1 is the accepting edge; done is expected high after edge 19.
  task automatic run_job(input string nm, input logic [15:0] d,
                         input logic m, input int ec, input int ef,
                         input int ep, input int ec1, input int ep1,
                         input bit poke);
    int edges;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.data_in   = d;
    bus.msb_first = m;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
    while (edges < 40 && bus.done !== 1'b1) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      bus.start = poke && (edges == 6 || edges == 11);
    end
    bus.start = 1'b0;
    chk({nm, "_latency"}, 64'(edges), 64'd19);
    chk({nm, "_cnt"}, 64'(bus.det_count), 64'(ec));
    chk({nm, "_found"}, 64'(bus.found), 64'(ef));
    chk({nm, "_pos"}, 64'(bus.first_pos), 64'(ep));
    chk({nm, "_cnt_sat"}, 64'(bus1.det_count), 64'(ec1));
    chk({nm, "_pos_sat"}, 64'(bus1.first_pos), 64'(ep1));
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({nm, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int edges;
    int pulses;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.data_in   = '0;
    bus.msb_first = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_cnt", 64'(bus.det_count), 64'd0);
    chk("rst_found", 64'(bus.found), 64'd0);
    chk("rst_pos", 64'(bus.first_pos), 64'd0);

    bus.start   = 1'b1;
    bus.data_in = 16'h9CC0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_prio", 64'(bus.busy), 64'd0);
    reset     = 1'b0;
    bus.start = 1'b0;

    run_job("msb", 16'h9CC0, 1'b1, 2, 1, 4, 1, 4, 1'b0);
    run_job("lsb", 16'h9CC0, 1'b0, 1, 1, 11, 1, 11, 1'b0);
    run_job("zero", 16'h0000, 1'b1, 0, 0, 0, 0, 0, 1'b0);
    run_job("poke", 16'h9CC0, 1'b1, 2, 1, 4, 1, 4, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_busy", 64'(bus.busy), 64'd0);
    chk("hold_cnt", 64'(bus.det_count), 64'd2);
    chk("hold_pos", 64'(bus.first_pos), 64'd4);

    // start held while done is high: ignored, then accepted from IDLE
    bus.start     = 1'b1;
    bus.data_in   = 16'h9CC0;
    bus.msb_first = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(edges);
    chk("dstart_latency", 64'(edges), 64'd19);
    bus.start   = 1'b1;
    bus.data_in = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    chk("dstart_ignored", 64'(bus.busy), 64'd0);
    chk("dstart_cnt_hold", 64'(bus.det_count), 64'd2);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("dstart_accept", 64'(bus.busy), 64'd1);
    wait_done(edges);
    chk("dstart2_latency", 64'(edges), 64'd19);
    chk("dstart2_cnt", 64'(bus.det_count), 64'd0);
    chk("dstart2_found", 64'(bus.found), 64'd0);

    // reset at SHIFT index 7 (after edge 9 counting the accept edge)
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'h9CC0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_partial_cnt", 64'(bus.det_count), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_cnt", 64'(bus.det_count), 64'd0);
    chk("abort_found", 64'(bus.found), 64'd0);
    chk("abort_pos", 64'(bus.first_pos), 64'd0);
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_job("fresh", 16'h9CC0, 1'b1, 2, 1, 4, 1, 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
